// File: rtl/mstq_arbiter.sv
// Packet-granular round-robin arbiter feeding the master write FIFO.
// Two TLP sources, grant locked per packet, junk discard and error status.
module mstq_arbiter #(
  parameter int CntWidth = 16
) (
  input  logic                pcie_clk,
  input  logic                sys_rst,
  input  logic                p0_vld,
  input  logic [17:0]         p0_dat,
  output logic                p0_rdy,
  input  logic                p1_vld,
  input  logic [17:0]         p1_dat,
  output logic                p1_rdy,
  output logic [17:0]         mst_din,
  output logic                mst_wr_en,
  input  logic                mst_full,
  output logic [1:0]          grant,
  output logic [CntWidth-1:0] pkt_cnt0,
  output logic [CntWidth-1:0] pkt_cnt1,
  output logic [1:0]          err,
  input  logic                err_clr
);

  // State encoding doubles as the one-hot grant vector
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PKT0 = 2'b01;
  localparam logic [1:0] S_PKT1 = 2'b10;

  logic [1:0]          r_state;
  logic                r_last;
  logic                r_first;
  logic [CntWidth-1:0] r_cnt0;
  logic [CntWidth-1:0] r_cnt1;
  logic [1:0]          r_err;

  logic        w_idle;
  logic [1:0]  w_cand;
  logic [1:0]  w_junk;
  logic        w_pick1;
  logic        w_vld;
  logic [17:0] w_dat;
  logic        w_wr;
  logic        w_eop;
  logic        w_sop_err;
  logic [1:0]  w_err_set;

  assign w_idle  = (r_state == S_IDLE);
  assign w_cand  = {p1_vld & p1_dat[17], p0_vld & p0_dat[17]};
  assign w_junk  = {p1_vld & ~p1_dat[17], p0_vld & ~p0_dat[17]}
                 & {2{w_idle}};
  assign w_pick1 = w_cand[1] & (~w_cand[0] | ~r_last);

  always_comb begin
    w_vld = 1'b0;
    w_dat = '0;
    unique case (1'b1)
      r_state[0]: begin
        w_vld = p0_vld;
        w_dat = p0_dat;
      end
      r_state[1]: begin
        w_vld = p1_vld;
        w_dat = p1_dat;
      end
      default: ;
    endcase
  end

  assign w_wr      = ~w_idle & w_vld & ~mst_full;
  assign w_eop     = w_wr & w_dat[16];
  assign w_sop_err = w_wr & w_dat[17] & ~r_first;
  assign w_err_set = w_junk | ({2{w_sop_err}} & r_state);

  assign mst_wr_en = w_wr;
  assign mst_din   = w_wr ? w_dat : 18'd0;
  assign p0_rdy    = r_state[0] ? ~mst_full : w_junk[0];
  assign p1_rdy    = r_state[1] ? ~mst_full : w_junk[1];
  assign grant     = r_state;
  assign pkt_cnt0  = r_cnt0;
  assign pkt_cnt1  = r_cnt1;
  assign err       = r_err;

  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_first <= 1'b0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
      r_err   <= 2'b00;
    end else begin
      r_err <= (r_err & ~{2{err_clr}}) | w_err_set;
      if (w_idle) begin
        if (|w_cand) begin
          r_state <= w_pick1 ? S_PKT1 : S_PKT0;
          r_last  <= w_pick1;
          r_first <= 1'b1;
        end
      end else begin
        if (w_wr)
          r_first <= 1'b0;
        if (w_eop) begin
          r_state <= S_IDLE;
          if (r_state[0])
            r_cnt0 <= r_cnt0 + 1'b1;
          else
            r_cnt1 <= r_cnt1 + 1'b1;
        end
      end
    end
  end

endmodule
